// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: slice width and the legality test for
// splitting WIDTH bits into STAGES equal slices.
package adder_pkg;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit split_ok(input int width, input int stages);
    return (stages > 0) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple of full_adder cells. c_msb is the carry into the
// slice's top bit, which the top slice needs for signed overflow.
module adder_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    full_adder u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (carry[gi]),
      .sum  (sum[gi]),
      .cout (carry[gi+1])
    );
  end

  assign cout  = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of every ripple slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES registered ripple slices with operand
// skew and result deskew, valid/ready handshake, and a global advance enable.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipelined_adder: WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO  = gi * CHUNK;
    localparam int REM = WIDTH - LO;

    // Operand bits still waiting to be added arrive here already skewed by gi cycles.
    logic [REM-1:0]      a_in;
    logic [REM-1:0]      b_in;
    logic                c_in;
    logic                v_in;
    logic [CHUNK-1:0]    slice_sum;
    logic                slice_cout;
    logic                slice_cmsb;
    logic [LO+CHUNK-1:0] sum_next;
    logic [LO+CHUNK-1:0] sum_reg;
    logic                carry_reg;
    logic                valid_reg;

    if (gi == 0) begin : g_head
      assign a_in     = a;
      assign b_in     = b_eff;
      assign c_in     = c0;
      assign v_in     = in_valid;
      assign sum_next = slice_sum;
    end else begin : g_body
      assign a_in     = g_stage[gi-1].g_skew.a_reg;
      assign b_in     = g_stage[gi-1].g_skew.b_reg;
      assign c_in     = g_stage[gi-1].carry_reg;
      assign v_in     = g_stage[gi-1].valid_reg;
      assign sum_next = {slice_sum, g_stage[gi-1].sum_reg};
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a     (a_in[CHUNK-1:0]),
      .b     (b_in[CHUNK-1:0]),
      .cin   (c_in),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .c_msb (slice_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        sum_reg   <= '0;
      end else if (adv) begin
        valid_reg <= v_in;
        carry_reg <= slice_cout;
        sum_reg   <= sum_next;
      end
    end

    if (gi < STAGES - 1) begin : g_skew
      logic [REM-CHUNK-1:0] a_reg;
      logic [REM-CHUNK-1:0] b_reg;
      logic                 unused_cmsb;

      assign unused_cmsb = slice_cmsb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (adv) begin
          a_reg <= a_in[REM-1:CHUNK];
          b_reg <= b_in[REM-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic ovf_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_reg <= 1'b0;
        end else if (adv) begin
          ovf_reg <= slice_cmsb ^ slice_cout;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_reg;
  assign sum       = g_stage[STAGES-1].sum_reg;
  assign cout      = g_stage[STAGES-1].carry_reg;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_reg;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, STAGES=4): reset, carry ripple,
// overflow, subtract, streaming with backpressure, and reset while busy.
module tb_pipelined_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operand pair, then waits (bounded) for its result; no checking here.
  task automatic single_op(input logic [15:0] va, input logic [15:0] vb,
                           input logic vcin, input logic vsub,
                           output logic [15:0] rs, output logic rc, output logic ro,
                           output int lat);
    @(negedge clk);
    a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rs = sum; rc = cout; ro = ovf;
    $display("op a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
             va, vb, vcin, vsub, rs, rc, ro, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0000) begin
      errors++;
      $display("FAIL reset_hold: out_valid=%b sum=%h, want 0 and 0000", out_valid, sum);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: v=%b sum=%h cout=%b ovf=%b, want 0/0000/0/0",
               out_valid, sum, cout, ovf);
    end
  endtask

  task automatic test_carry_ripple();
    logic [15:0] rs;
    logic        rc, ro;
    int          lat;
    single_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL ripple_latency: got %0d want 4", lat);
    end
    checks++;
    if (rs !== 16'h0000 || rc !== 1'b1 || ro !== 1'b0) begin
      errors++;
      $display("FAIL ripple_result: sum=%h cout=%b ovf=%b, want 0000/1/0", rs, rc, ro);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] rs;
    logic        rc, ro;
    int          lat;
    single_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    checks++;
    if (rs !== 16'h8000 || rc !== 1'b0 || ro !== 1'b1 || lat !== 4) begin
      errors++;
      $display("FAIL ovf_pos: sum=%h cout=%b ovf=%b lat=%0d, want 8000/0/1/4", rs, rc, ro, lat);
    end
    single_op(16'h8000, 16'h8000, 1'b0, 1'b0, rs, rc, ro, lat);
    checks++;
    if (rs !== 16'h0000 || rc !== 1'b1 || ro !== 1'b1 || lat !== 4) begin
      errors++;
      $display("FAIL ovf_neg: sum=%h cout=%b ovf=%b lat=%0d, want 0000/1/1/4", rs, rc, ro, lat);
    end
  endtask

  task automatic test_subtract();
    logic [15:0] rs;
    logic        rc, ro;
    int          lat;
    single_op(16'h0005, 16'h0007, 1'b1, 1'b1, rs, rc, ro, lat);
    checks++;
    if (rs !== 16'hFFFE || rc !== 1'b0 || ro !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: sum=%h cout=%b ovf=%b, want fffe/0/0", rs, rc, ro);
    end
    single_op(16'h0007, 16'h0005, 1'b0, 1'b1, rs, rc, ro, lat);
    checks++;
    if (rs !== 16'h0002 || rc !== 1'b1 || ro !== 1'b0) begin
      errors++;
      $display("FAIL sub_noborrow: sum=%h cout=%b ovf=%b, want 0002/1/0", rs, rc, ro);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    logic        vs [8];
    logic [15:0] es [8];
    logic        ec [8];
    logic        eo [8];
    logic [15:0] beff;
    logic [17:0] hold;
    int          issued, rcv, c, dup;
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vc[i] = 1'($urandom_range(0, 1));
      vs[i] = 1'($urandom_range(0, 1));
      beff  = vs[i] ? ~vb[i] : vb[i];
      {ec[i], es[i]} = {1'b0, va[i]} + {1'b0, beff} + {16'h0000, (vs[i] | vc[i])};
      eo[i] = (va[i][15] == beff[15]) && (es[i][15] != va[i][15]);
    end
    issued = 0; rcv = 0; c = 0; hold = '0;
    while (rcv < 8 && c < 60) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      if (issued < 8) begin
        in_valid = 1'b1; a = va[issued]; b = vb[issued]; cin = vc[issued]; sub = vs[issued];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 5 && c <= 7) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_c%0d: in_ready=%b out_valid=%b, want 0 and 1", c, in_ready, out_valid);
        end
        if (c == 5) begin
          hold = {sum, cout, ovf};
        end else begin
          checks++;
          if ({sum, cout, ovf} !== hold) begin
            errors++;
            $display("FAIL stall_stable_c%0d: got %h want %h", c, {sum, cout, ovf}, hold);
          end
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (rcv >= 8 || sum !== es[rcv] || cout !== ec[rcv] || ovf !== eo[rcv]) begin
          errors++;
          $display("FAIL stream_%0d: sum=%h cout=%b ovf=%b, want %h/%b/%b",
                   rcv, sum, cout, ovf, es[rcv], ec[rcv], eo[rcv]);
        end else begin
          $display("stream result %0d sum=%h cout=%b ovf=%b", rcv, sum, cout, ovf);
        end
        rcv++;
      end
      if (in_valid && in_ready === 1'b1) issued++;
      c++;
    end
    checks++;
    if (rcv != 8) begin
      errors++;
      $display("FAIL stream_count: received %0d want 8 (timeout)", rcv);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    dup = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) dup++;
    end
    checks++;
    if (dup != 0) begin
      errors++;
      $display("FAIL stream_duplicates: %0d extra valid cycles, want 0", dup);
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] rs;
    logic        rc, ro;
    int          lat, leaked;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'(16'h1111 * (i + 1)); b = 16'h0101; cin = 1'b0; sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: out_valid=%b want 1 before reset", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_async: out_valid=%b sum=%h, want 0 and 0000", out_valid, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: in_ready=%b want 1", in_ready);
    end
    leaked = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) leaked++;
    end
    checks++;
    if (leaked != 0) begin
      errors++;
      $display("FAIL midrst_leak: %0d valid cycles after reset, want 0", leaked);
    end
    single_op(16'h1234, 16'h4321, 1'b1, 1'b0, rs, rc, ro, lat);
    checks++;
    if (rs !== 16'h5556 || rc !== 1'b0 || ro !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL midrst_after: sum=%h cout=%b ovf=%b lat=%0d, want 5556/0/0/4", rs, rc, ro, lat);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    test_reset();
    test_carry_ripple();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised successor to the single-bit full adder: a WIDTH-bit add/subtract unit split into STAGES registered carry-ripple slices.
- Accepts one operand pair per cycle through a valid/ready handshake. Returns sum, carry-out and signed overflow STAGES cycles later.
- Used wherever a wide adder must close timing at the system clock. Each slice is a ripple chain of existing full_adder cells.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline slices; each slice adds CHUNK = WIDTH/STAGES bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept the operand pair this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a + ~b + 1.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1; for sub, 1 = no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: while rst_n=0, every valid bit, data, skew and carry register clears to 0 immediately. Outputs are out_valid=0, sum=0, cout=0, ovf=0.
- Advance enable: adv = out_ready | ~out_valid. All pipeline registers advance together when adv=1 and hold otherwise.
- in_ready = adv. This is combinational from out_ready and out_valid; no combinational path from in_valid.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Valid bits: a valid bit enters stage 0 on adv, loaded with in_valid. Bubbles move with the pipeline; they are not collapsed.
- Operand conditioning at capture: b_eff = sub ? ~b : b, c0 = sub ? 1 : cin.
- Slice k (k = 0..STAGES-1):
  - adds bits [k*CHUNK +: CHUNK] of a and b_eff plus the carry registered by slice k-1 (c0 for k=0);
  - registers its CHUNK-bit result and carry-out.
- Skew and deskew: slice-k operand bits are delayed k cycles in skew registers. Completed low slices are delayed in deskew registers so all slices of one operation exit in the same cycle.
- Latency: exactly STAGES cycles from input transfer to out_valid when unstalled. Throughput is 1 result per cycle.
- Output fields:
  - cout = carry out of the top slice;
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, tracked within the top slice.
- Output stability: sum, cout and ovf stay stable while out_valid=1 and out_ready=0.
- Stall: with out_valid=1 and out_ready=0, nothing moves and in_ready=0. No operation is lost or duplicated, and order is preserved.
- Release: when out_ready returns to 1, flow resumes in the same cycle.
- Data when invalid: outputs with out_valid=0 are don't-care for checking, but must not be X after reset.
- Reset mid-operation: all in-flight operations are discarded and never emerge after release. First accept is possible on the first edge after rst_n deasserts.
- Degenerate case STAGES=1: single registered adder, latency 1.

Decomposition:
- Package adder_pkg holds:
  - localparam function chunk_w(WIDTH, STAGES);
  - elaboration-time check that WIDTH % STAGES == 0, which errors out otherwise.
- Sub-module adder_slice, parameter CHUNK: a combinational ripple of CHUNK full_adder instances, outputting sum chunk, carry-out and carry into its MSB. It is instantiated STAGES times.
- Registers (skew, deskew, valid) live in pipelined_adder.

Test Plan (WIDTH=16, STAGES=4):
- Reset: hold rst_n=0 for 3 cycles, then release → out_valid=0, sum=0x0000, in_ready=1 on the first cycle after release.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0, sub=0, one transfer → exactly 4 cycles later: out_valid=1, sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (cin must be ignored) → sum=0xFFFE, cout=0, ovf=0. Then a=0x0007, b=0x0005, sub=1 → sum=0x0002, cout=1.
- Backpressure: stream 8 random vectors back-to-back with out_ready held 0 for cycles 5-7 → in_ready=0 during the stall, outputs held stable, all 8 results emerge in order and match the golden model, no duplicates.
- Reset mid-stream: 3 operations in flight, pulse rst_n low for 1 cycle → out_valid drops to 0 asynchronously, none of the 3 results ever appear; a new vector issued after release returns correctly after 4 cycles.
